fdiv_seq: RTL
=============

FDIV_SEQ -- requirements
Module: fdiv_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports listed clock first, then reset.
REQ-002 clk  input  1  Rising-edge system clock.
REQ-003 rst  input  1  Reset: asynchronous assertion, active-high.
REQ-004 x1  input  32  Dividend (IEEE-754 single); sampled only on the accepting edge.
REQ-005 x2  input  32  Divisor (IEEE-754 single); sampled only on the accepting edge.
REQ-006 in_valid  input  1  Operand pair is present.
REQ-007 in_ready  output  1  High exactly when the state is IDLE.
REQ-008 y  output  32  Quotient; registered; held until the result is consumed.
REQ-009 out_valid  output  1  y is valid; high exactly when the state is DONE.
REQ-010 out_ready  input  1  Consumer accepts y.

Function
REQ-011 Acceptance SHALL occur on a rising edge where in_valid && in_ready; x1 and x2 are captured on that edge, and later input changes SHALL be ignored.
REQ-012 States SHALL be IDLE, DIV, NORM and DONE: IDLE->DIV on acceptance; DIV->NORM after 26 iterations; NORM->DONE after 1 edge; DONE->IDLE on out_valid && out_ready.
REQ-013 An operand with exponent field 0 SHALL be treated as zero; NaN and Inf inputs SHALL get no special handling beyond their exponent/mantissa fields.
REQ-014 Special cases SHALL go IDLE->DONE on the accepting edge: e2==0 gives {s1^s2, 8'hFF, 23'b0}; else e1==0 gives {s1^s2, 31'b0}. The divisor-zero case has priority.
REQ-015 Sign SHALL be s1 XOR s2 in every case.
REQ-016 ma={1,m1} and mb={1,m2} SHALL be 24-bit; DIV performs restoring division, 1 quotient bit per edge using a 5-bit iteration counter, producing q = floor(ma*2^25/mb), which lies in [2^24, 2^26).
REQ-017 Normalisation in NORM SHALL be:
- if q[25]=1: mant=q[24:2]+q[1] and e=e1-e2+127;
- else: mant=q[23:1]+q[0] and e=e1-e2+126.
REQ-018 Rounding SHALL be round-half-up. If mant overflows 23 bits, mant SHALL become 0 and e SHALL be incremented by 1.
REQ-019 e SHALL be computed signed, with at least 10 bits.
REQ-020 Exponent range SHALL be handled as follows:
- e<=0 gives a magnitude of 0 (sign kept);
- e>=255 gives exponent 8'hFF with mant 0;
- otherwise y={sign, e[7:0], mant}.
REQ-021 Latency: for a non-special operation, out_valid SHALL rise on the 27th rising edge after the accepting edge.
REQ-022 Latency: for a special case, out_valid SHALL rise on the accepting edge itself.
REQ-023 In DONE, y and out_valid SHALL hold stable indefinitely while out_ready=0.
REQ-024 On the consuming edge, out_valid SHALL fall; in_ready SHALL rise on that same edge, so there is no same-edge turnaround.
REQ-025 in_valid outside IDLE and out_ready outside DONE SHALL be ignored.
REQ-026 Throughput SHALL be one operation in flight at a time.

Reset
REQ-027 When rst is asserted, the block SHALL immediately, asynchronously and in any state, force: state=IDLE, y=0, out_valid=0, iteration counter=0, internal operands=0.
REQ-028 A reset during DIV or NORM SHALL abort the operation, and no result from it SHALL ever appear.
REQ-029 in_ready SHALL be 1 during and after reset.
REQ-030 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-031 The bench SHALL cover the following directed scenarios:
- x1=0x40C00000, x2=0x40000000 (6.0/2.0) -> y=0x40400000, out_valid on the 27th edge after acceptance.
- x1=0x3F800000, x2=0x40400000 (1.0/3.0) -> y=0x3EAAAAAB (exercises the q[25]=0 path with round-up).
- x1=0xBF800000, x2=0x00000000 -> y=0xFF800000, out_valid on the accepting edge; x1=0x00000000, x2=0xC0000000 -> y=0x80000000.
- x1=0x7F000000, x2=0x00800000 -> y=0x7F800000 (overflow); x1=0x00800000, x2=0x7F000000 -> y=0x00000000 (underflow).
- 6.0/2.0 with out_ready=0 for 5 cycles after out_valid -> y stays 0x40400000, in_ready stays 0, a toggling in_valid is ignored; out_ready=1 -> IDLE on the next edge.
- rst pulsed at the 10th DIV iteration -> y=0, out_valid=0, in_ready=1 immediately; a new 1.0/3.0 op then completes correctly.

Source files
------------

// File: rtl/fdiv_seq.sv
// Sequential IEEE-754 single-precision divider: 26-step restoring mantissa
// division, one normalise/round edge, then a held result with valid/ready handshake.
module fdiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] y,
    output logic        out_valid,
    input  logic        out_ready
);
    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    state_t       state_q, state_d;
    logic         sign_q, sign_d;
    logic [7:0]   ea_q, ea_d;
    logic [7:0]   eb_q, eb_d;
    logic [23:0]  mb_q, mb_d;
    logic [24:0]  rem_q, rem_d;
    logic [25:0]  quo_q, quo_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [31:0]  y_q, y_d;

    logic         sign_in;
    logic [23:0]  rem_sub;
    logic signed [9:0] exp_n;
    logic [23:0]  mant_n;
    logic [31:0]  norm_res;

    assign sign_in = x1[31] ^ x2[31];
    // The partial remainder is always below 2*mb, so the low 24 bits of the
    // difference are exact whenever the subtraction is taken.
    assign rem_sub = rem_q[23:0] - mb_q;

    always_comb begin
        if (quo_q[25]) begin
            mant_n = {1'b0, quo_q[24:2]} + {23'd0, quo_q[1]};
            exp_n  = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd127;
        end else begin
            mant_n = {1'b0, quo_q[23:1]} + {23'd0, quo_q[0]};
            exp_n  = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd126;
        end
        if (mant_n[23]) begin
            mant_n = 24'd0;
            exp_n  = exp_n + 10'sd1;
        end
        if (exp_n <= 10'sd0) begin
            norm_res = {sign_q, 31'd0};
        end else if (exp_n >= 10'sd255) begin
            norm_res = {sign_q, 8'hFF, 23'd0};
        end else begin
            norm_res = {sign_q, exp_n[7:0], mant_n[22:0]};
        end
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        mb_d    = mb_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = sign_in;
                    ea_d   = x1[30:23];
                    eb_d   = x2[30:23];
                    mb_d   = {1'b1, x2[22:0]};
                    rem_d  = {2'b01, x1[22:0]};
                    quo_d  = 26'd0;
                    cnt_d  = 5'd0;
                    // Divisor zero wins over dividend zero.
                    if (x2[30:23] == 8'd0) begin
                        y_d     = {sign_in, 8'hFF, 23'd0};
                        state_d = DONE;
                    end else if (x1[30:23] == 8'd0) begin
                        y_d     = {sign_in, 31'd0};
                        state_d = DONE;
                    end else begin
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                if (rem_q >= {1'b0, mb_q}) begin
                    quo_d = {quo_q[24:0], 1'b1};
                    rem_d = {rem_sub, 1'b0};
                end else begin
                    quo_d = {quo_q[24:0], 1'b0};
                    rem_d = {rem_q[23:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd25) begin
                    cnt_d   = 5'd0;
                    state_d = NORM;
                end
            end
            NORM: begin
                y_d     = norm_res;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            ea_q    <= 8'd0;
            eb_q    <= 8'd0;
            mb_q    <= 24'd0;
            rem_q   <= 25'd0;
            quo_q   <= 26'd0;
            cnt_q   <= 5'd0;
            y_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            mb_q    <= mb_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = y_q;
endmodule
